// File: rtl/jtpopeye_objdma.sv
// Object DMA: on an armed VB rising edge, borrows the CPU bus and streams the
// sprite table from work RAM to the object buffer as ROHVS/ROHVCK/obj_dout.
module jtpopeye_objdma #(
   parameter int          N_OBJ     = 64,
   parameter int          OBJ_BYTES = 4,
   parameter logic [12:0] BASE      = 13'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic        VB,
   input  logic        dma_arm,
   output logic        busreq,
   input  logic        busak_n,
   output logic [12:0] ram_addr,
   input  logic [7:0]  ram_din,
   output logic        ROHVS,
   output logic        ROHVCK,
   output logic [7:0]  obj_dout,
   output logic        busy,
   output logic        dma_miss
);

   localparam int TOTAL = N_OBJ * OBJ_BYTES;
   localparam int CW    = $clog2(TOTAL) + 1;
   localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

   typedef enum logic [2:0] {IDLE, REQ, START, READ, XFER, DONE} state_t;

   state_t        st;
   logic          vb_q;
   logic          armed;
   logic [CW-1:0] cnt;
   logic          vb_rise;

   assign vb_rise = VB & ~vb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= IDLE;
         vb_q     <= 1'b0;
         armed    <= 1'b0;
         cnt      <= '0;
         busreq   <= 1'b0;
         ram_addr <= BASE;
         ROHVS    <= 1'b0;
         ROHVCK   <= 1'b0;
         obj_dout <= '0;
         busy     <= 1'b0;
         dma_miss <= 1'b0;
      end else if (cen) begin
         vb_q     <= VB;
         ROHVS    <= 1'b0;
         ROHVCK   <= 1'b0;
         dma_miss <= 1'b0;
         if (dma_arm && !busy) armed <= 1'b1;
         case (st)
            IDLE: if (vb_rise && armed) begin
               st     <= REQ;
               busreq <= 1'b1;
               busy   <= 1'b1;
               armed  <= 1'b0;
            end
            // a grant in the same cycle as VB falling still wins
            REQ: if (!busak_n) begin
               st <= START;
            end else if (!VB) begin
               st       <= IDLE;
               busreq   <= 1'b0;
               busy     <= 1'b0;
               dma_miss <= 1'b1;
            end
            START: if (!busak_n) begin
               ROHVS    <= 1'b1;
               ram_addr <= BASE;
               cnt      <= '0;
               st       <= READ;
            end
            READ: if (!busak_n) st <= XFER;
            XFER: if (!busak_n) begin
               obj_dout <= ram_din;
               ROHVCK   <= 1'b1;
               cnt      <= cnt + CW'(1);
               ram_addr <= ram_addr + 13'd1;
               st       <= (cnt == LAST) ? DONE : READ;
            end
            DONE: begin
               busreq <= 1'b0;
               if (busak_n) begin
                  busy <= 1'b0;
                  st   <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Bench for jtpopeye_objdma: control-path vector table, full randomized
// transfers against a RAM/byte-order model, address wrap and reset abort.
module tb_jtpopeye_objdma;

   localparam int TOTAL = 64 * 4;

   logic        clk = 1'b0;
   logic        rst_n, cen, VB, dma_arm, busak_n;
   logic        busreq, ROHVS, ROHVCK, busy, dma_miss;
   logic [12:0] ram_addr;
   logic [7:0]  ram_din, obj_dout;

   logic        busak2_n, busreq2, rohvs2, rohvck2, busy2, miss2;
   logic [12:0] ram_addr2;
   logic [7:0]  ram_din2, obj_dout2;

   logic [7:0]  mem [0:8191];

   int nvec = 0, nfail = 0;
   int nbyte, nrohvs, idx2, n2 = 0;

   always #5 clk = ~clk;

   jtpopeye_objdma #(.N_OBJ(64), .OBJ_BYTES(4), .BASE(13'h0)) u_dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .VB(VB), .dma_arm(dma_arm),
      .busreq(busreq), .busak_n(busak_n), .ram_addr(ram_addr), .ram_din(ram_din),
      .ROHVS(ROHVS), .ROHVCK(ROHVCK), .obj_dout(obj_dout), .busy(busy), .dma_miss(dma_miss));

   jtpopeye_objdma #(.N_OBJ(1), .OBJ_BYTES(4), .BASE(13'h1FFE)) u_wrap (
      .clk(clk), .rst_n(rst_n), .cen(cen), .VB(VB), .dma_arm(dma_arm),
      .busreq(busreq2), .busak_n(busak2_n), .ram_addr(ram_addr2), .ram_din(ram_din2),
      .ROHVS(rohvs2), .ROHVCK(rohvck2), .obj_dout(obj_dout2), .busy(busy2), .dma_miss(miss2));

   // synchronous RAM: data one cen cycle after the address
   always @(posedge clk) if (cen) begin
      ram_din  <= mem[ram_addr];
      ram_din2 <= mem[ram_addr2];
   end

   // the wrap-test instance gets an automatic CPU grant
   always @(posedge clk or negedge rst_n)
      if (!rst_n) busak2_n <= 1'b1;
      else        busak2_n <= ~busreq2;

   typedef struct packed {
      logic cen, vb, arm, ak_n;
      logic busreq, busy, miss;
   } vec_t;
   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor(input logic prev_ak);
      if (!rst_n) return;
      if (ROHVS) nrohvs++;
      if (ROHVCK) begin
         chk("strobe_while_released", {31'd0, prev_ak}, 0);
         chk("rohvs_before_bytes", nrohvs, 1);
         if (nbyte < TOTAL) chk($sformatf("byte%0d", nbyte), {24'd0, obj_dout}, {24'd0, mem[nbyte]});
         else chk("extra_strobe", nbyte, TOTAL - 1);
         nbyte++;
      end
      if (rohvs2) idx2 = 0;
      if (rohvck2) begin
         if (idx2 < 4) chk($sformatf("wrap_byte%0d", idx2), {24'd0, obj_dout2},
                           {24'd0, mem[(8190 + idx2) % 8192]});
         else chk("wrap_extra_strobe", idx2, 3);
         idx2++;
         n2++;
      end
   endtask

   task automatic tick();
      logic prev_ak;
      prev_ak = busak_n;
      @(posedge clk); #1;
      monitor(prev_ak);
   endtask

   task automatic start_req();
      nbyte = 0; nrohvs = 0;
      VB = 1'b0; tick();
      dma_arm = 1'b1; tick();
      dma_arm = 1'b0; VB = 1'b1; tick();
      chk("req_on_vb", {31'd0, busreq}, 1);
      chk("busy_on_vb", {31'd0, busy}, 1);
   endtask

   task automatic run_transfer(input int gdelay, input int stall_at, input int stall_len,
                               input bit check_timing);
      int  cyc;
      bit  stalled;
      start_req();
      repeat (gdelay) tick();
      chk("no_rohvs_before_grant", nrohvs, 0);
      busak_n = 1'b0;
      VB = 1'b0;
      cyc = 0; stalled = 0;
      while (busreq && cyc < 3000) begin
         if (!stalled && stall_len > 0 && nbyte == stall_at) begin
            stalled = 1;
            busak_n = 1'b1;
            repeat (stall_len) tick();
            cyc += stall_len;
            busak_n = 1'b0;
         end
         tick();
         cyc++;
      end
      if (cyc >= 3000) chk("xfer_timeout", 1, 0);
      if (check_timing) chk("xfer_cycles", cyc - 1, 2 + 2 * TOTAL);
      chk("strobes", nbyte, TOTAL);
      chk("rohvs_count", nrohvs, 1);
      busak_n = 1'b1;
      cyc = 0;
      while (busy && cyc < 10) begin tick(); cyc++; end
      chk("busy_release", {31'd0, busy}, 0);
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
      rst_n = 1'b0; cen = 1'b1; VB = 1'b0; dma_arm = 1'b0; busak_n = 1'b1;
      nbyte = 0; nrohvs = 0; idx2 = 0;
      #1;
      chk("rst_busreq", {31'd0, busreq}, 0);
      chk("rst_addr", {19'd0, ram_addr}, 0);
      chk("rst_outs", {28'd0, ROHVS, ROHVCK, busy, dma_miss}, 0);
      chk("rst_dout", {24'd0, obj_dout}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      //            cen vb arm akn   req busy miss
      tbl[0]  = '{1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0};
      tbl[1]  = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0};
      tbl[2]  = '{1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0};
      tbl[3]  = '{1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0};
      tbl[4]  = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0};
      tbl[5]  = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0};
      tbl[6]  = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1};
      tbl[7]  = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0};
      tbl[8]  = '{1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0};
      tbl[9]  = '{1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0};
      tbl[10] = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0};
      tbl[11] = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0};
      tbl[12] = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1};
      tbl[13] = '{1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0};
      tbl[14] = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0};
      for (int i = 0; i < 15; i++) begin
         cen = tbl[i].cen; VB = tbl[i].vb; dma_arm = tbl[i].arm; busak_n = tbl[i].ak_n;
         tick();
         chk($sformatf("tbl%0d_busreq", i), {31'd0, busreq}, {31'd0, tbl[i].busreq});
         chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
         chk($sformatf("tbl%0d_miss", i), {31'd0, dma_miss}, {31'd0, tbl[i].miss});
         chk($sformatf("tbl%0d_strobes", i), {30'd0, ROHVS, ROHVCK}, 0);
      end
      cen = 1'b1; dma_arm = 1'b0; VB = 1'b0;
      repeat (12) tick();

      run_transfer(3, 0, 0, 1'b1);
      run_transfer(2, 11, 5, 1'b0);
      for (int r = 0; r < 4; r++)
         run_transfer(int'($urandom_range(0, 6)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 6)), 1'b0);

      // reset in the middle of a transfer
      begin
         int cyc;
         start_req();
         busak_n = 1'b0;
         cyc = 0;
         while (nbyte < 100 && cyc < 1000) begin tick(); cyc++; end
         if (cyc >= 1000) chk("reset_test_timeout", 1, 0);
         rst_n = 1'b0;
         #1;
         chk("midrst_busreq", {31'd0, busreq}, 0);
         chk("midrst_addr", {19'd0, ram_addr}, 0);
         chk("midrst_outs", {28'd0, ROHVS, ROHVCK, busy, dma_miss}, 0);
         chk("midrst_dout", {24'd0, obj_dout}, 0);
         busak_n = 1'b1; VB = 1'b0; idx2 = 0;
         repeat (2) @(posedge clk);
         #1 rst_n = 1'b1;
         tick();
      end
      run_transfer(1, 0, 0, 1'b1);
      chk("wrap_instance_ran", {31'd0, n2 >= 4}, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
